// File: rtl/tdm_demux_if.sv
// Link-side bundle for tdm_demux: the multiplexed word stream in, the per-channel hold registers and status flags out.
// The stream has valid-only semantics: a word transfers on every rising clk edge with valid_in=1; there is no ready and no backpressure.
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic [WIDTH-1:0]          data_in;
  logic                      valid_in;
  logic                      sync_in;
  logic                      par_in;
  logic [CHANNELS*WIDTH-1:0] ch_out;
  logic [CHANNELS-1:0]       ch_valid;
  logic                      frame_done;
  logic                      locked;
  logic                      sync_err;
  logic                      par_err;
  logic                      dbg_state;

  modport master (
    output data_in, valid_in, sync_in, par_in,
    input  ch_out, ch_valid, frame_done, locked, sync_err, par_err, dbg_state
  );

  modport slave (
    input  data_in, valid_in, sync_in, par_in,
    output ch_out, ch_valid, frame_done, locked, sync_err, par_err, dbg_state
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks to frame sync, counts slots and routes each valid word into its channel's hold register.
// Optional even-parity check on {data_in, par_in} is enabled with `define DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  localparam int               CNT_W = $clog2(CHANNELS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHANNELS - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          slot;
  logic [CHANNELS*WIDTH-1:0] ch_out_q;
  logic [CHANNELS-1:0]       ch_valid_q;
  logic                      frame_done_q;
  logic                      locked_q;
  logic                      sync_err_q;
  logic                      par_err_q;

  logic                      par_ok;
  logic                      accept;
  logic                      realign;
  logic                      lose;
  logic [CNT_W-1:0]          wr_idx;

`ifdef DEMUX_PARITY_EN
  assign par_ok = ~^{bus.data_in, bus.par_in};
`else
  logic unused_par;
  assign unused_par = bus.par_in;
  assign par_ok     = 1'b1;
`endif

  // accept: the word takes a slot (stored unless its parity is bad);
  // lose: a missing sync at slot 0 drops the word and falls back to HUNT.
  always_comb begin
    accept  = 1'b0;
    realign = 1'b0;
    lose    = 1'b0;
    wr_idx  = '0;
    if (bus.valid_in) begin
      if (state == HUNT) begin
        accept = bus.sync_in;
      end else if (bus.sync_in && slot != '0) begin
        accept  = 1'b1;
        realign = 1'b1;
      end else if (!bus.sync_in && slot == '0) begin
        lose = 1'b1;
      end else begin
        accept = 1'b1;
        wr_idx = slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      slot         <= '0;
      ch_out_q     <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= realign | lose;
      par_err_q    <= accept & ~par_ok;
      if (accept) begin
        state    <= LOCKED;
        locked_q <= 1'b1;
        slot     <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
        // A parity-failed word still consumes its slot so alignment holds.
        if (par_ok) begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (wr_idx == CNT_W'(k)) begin
              ch_out_q[k*WIDTH +: WIDTH] <= bus.data_in;
              ch_valid_q[k]              <= 1'b1;
            end
          end
          frame_done_q <= (wr_idx == LAST);
        end
      end
      if (lose) begin
        state    <= HUNT;
        locked_q <= 1'b0;
        slot     <= '0;
      end
    end
  end

  assign bus.ch_out     = ch_out_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.par_err    = par_err_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (CHANNELS=4, WIDTH=8): a behavioural frame model feeds an expected queue popped one cycle later.
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int RW = CH*W + CH + 4;

  logic clk;
  logic rst_n;

  tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] exp_q[$];

  // frame model
  logic [W-1:0] m_ch[CH];
  bit           m_locked;
  int           m_slot;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) m_ch[k] = '0;
    m_locked = 1'b0;
    m_slot   = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d, input bit p,
                            output logic [RW-1:0] rec);
    logic [CH-1:0] e_valid;
    bit e_fd, e_se, e_pe, pok, lose;
    int target;
    e_valid = '0; e_fd = 0; e_se = 0; e_pe = 0; lose = 0; target = -1;
`ifdef DEMUX_PARITY_EN
    pok = ((^{d, p}) == 1'b0);
`else
    pok = 1'b1;
`endif
    if (v) begin
      if (!m_locked) begin
        if (s) target = 0;
      end else if (s && m_slot != 0) begin
        e_se = 1; target = 0;
      end else if (!s && m_slot == 0) begin
        e_se = 1; lose = 1;
      end else begin
        target = m_slot;
      end
      if (target >= 0) begin
        if (pok) begin
          m_ch[target]    = d;
          e_valid[target] = 1'b1;
          e_fd            = (target == CH-1);
        end else begin
          e_pe = 1;
        end
        m_slot   = (target == CH-1) ? 0 : target + 1;
        m_locked = 1;
      end
      if (lose) begin
        m_slot   = 0;
        m_locked = 0;
      end
    end
    rec = {m_ch[3], m_ch[2], m_ch[1], m_ch[0], e_valid, e_fd, e_se, e_pe, m_locked};
  endtask

  task automatic compare_pending();
    logic [RW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ch_out", 64'(bus.ch_out), 64'(e[RW-1 -: CH*W]));
      check("flags", 64'({bus.ch_valid, bus.frame_done, bus.sync_err, bus.par_err, bus.locked}),
            64'(e[CH+3:0]));
    end
  endtask

  // driver: compare the previous cycle's result, then present a new input cycle
  task automatic drive_cycle(input bit v, input bit s, input logic [W-1:0] d, input bit p);
    logic [RW-1:0] rec;
    @(negedge clk);
    compare_pending();
    bus.valid_in = v;
    bus.sync_in  = s;
    bus.data_in  = d;
    bus.par_in   = p;
    model_step(v, s, d, p, rec);
    exp_q.push_back(rec);
  endtask

  task automatic send(input logic [W-1:0] d, input bit s);
    drive_cycle(1'b1, s, d, ^d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, W'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
    compare_pending();
    bus.valid_in = 1'b0;
    bus.sync_in  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({bus.ch_out, bus.ch_valid, bus.frame_done, bus.sync_err,
                    bus.par_err, bus.locked, bus.dbg_state}), 64'(0));
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.sync_in  = 1'b0;
    bus.data_in  = '0;
    bus.par_in   = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // lock from HUNT, back-to-back
    send(8'h11, 1); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle(2);

    // same frame with 3-cycle gaps
    send(8'h11, 1); idle(3); send(8'h22, 0); idle(3);
    send(8'h33, 0); idle(3); send(8'h44, 0); idle(3);

    // misplaced sync realigns to channel 0
    send(8'hA0, 1); send(8'hA1, 0); send(8'hA2, 1); send(8'hA3, 0);
    send(8'hA4, 0); send(8'hA5, 0);

    // missing sync at slot 0 drops lock; non-sync words ignored in HUNT
    send(8'h55, 0); idle(1);
    send(8'h66, 0); send(8'h77, 0); idle(1);
    send(8'h81, 1);

    // bad parity at slot 1 (counted only with the parity build)
    drive_cycle(1'b1, 1'b0, 8'h03, 1'b1);
    send(8'h04, 0); send(8'h05, 0);
    idle(1);

    // randomised traffic, occasional sync and parity faults
    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] d;
      bit v, s, p;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) == 0);
      d = W'($urandom_range(0, 255));
      p = (^d) ^ ($urandom_range(0, 7) == 0);
      drive_cycle(v, s, d, p);
    end
    idle(1);

    // reset mid-frame after slot 2
    send(8'hC0, 1); send(8'hC1, 0); send(8'hC2, 0);
    settle();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_locked", 64'({bus.locked, bus.dbg_state}), 64'(0));
    send(8'hC3, 0); idle(1);
    send(8'hD0, 1); send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0);
    settle();

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
